ptp_extts_sched: RTL

Multi-channel controller and arbiter for the external-timestamp latcher channels.
- Owns the arm/re-arm sequencing of CH_COUNT latcher instances and detects newly locked timestamps.
- Shares one event queue between the channels with round-robin arbitration.
- Presents a single ready/valid event stream to the register/DMA readout logic.
- Sits in the host-clock domain, downstream of the latchers' clk-side outputs.

---
 rtl/ptp_extts_sched.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ptp_extts_sched.sv
// Arm/re-arm sequencing and round-robin event queueing for CH_COUNT external-timestamp latchers.
// Define PTP_EXTTS_SCHED_STEP_EVT_EN to queue latcher step flags as step records.
module ptp_extts_sched #(
    parameter int unsigned CH_COUNT   = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned CHW = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1,
    localparam int unsigned PW  = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH_COUNT-1:0]   ch_enable,
    input  logic [CH_COUNT-1:0]   ch_locked,
    input  logic [CH_COUNT-1:0]   ch_step,
    input  logic [96*CH_COUNT-1:0] ch_ts,
    output logic [CH_COUNT-1:0]   ch_arm,
    output logic [95:0]           m_evt_ts,
    output logic [CHW-1:0]        m_evt_ch,
    output logic                  m_evt_step,
    output logic                  m_evt_valid,
    input  logic                  m_evt_ready,
    output logic [PW:0]           fifo_level,
    output logic [15:0]           ovf_count,
    input  logic                  clr_ovf
);

`ifdef PTP_EXTTS_SCHED_STEP_EVT_EN
    localparam bit StepEvtEn = 1'b1;
`else
    localparam bit StepEvtEn = 1'b0;
`endif

    localparam int unsigned EW  = 1 + CHW + 96;
    localparam int unsigned OCW = $clog2(CH_COUNT + 1);

    typedef enum logic [1:0] {StIdle, StArm, StWait, StPend} ch_state_e;

    ch_state_e           state_q [CH_COUNT];
    ch_state_e           state_d [CH_COUNT];
    logic [95:0]         hold_ts_q [CH_COUNT];
    logic [95:0]         hold_ts_d [CH_COUNT];
    logic [CH_COUNT-1:0] hold_step_q, hold_step_d;
    logic [CH_COUNT-1:0] seen_q, seen_d;
    logic [CH_COUNT-1:0] ovf_hit, req, arm_d, ch_arm_q;
    logic [CHW-1:0]      rr_ptr_q, rr_ptr_d, gnt_idx, arb_cand;
    logic [CHW:0]        arb_sum;
    logic                gnt;
    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [EW-1:0]       head;
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PW:0]         count_q, count_d;
    logic                fifo_full, fifo_empty, pop;
    logic [15:0]         ovf_q, ovf_d;
    logic [OCW-1:0]      ovf_inc;
    logic [16:0]         ovf_sum;

    always_comb begin
        for (int i = 0; i < int'(CH_COUNT); i++) begin
            req[i] = ch_enable[i] && (state_q[i] == StPend);
        end
    end

    // Round-robin search starting at rr_ptr; a full queue blocks grants even when popping.
    always_comb begin
        gnt      = 1'b0;
        gnt_idx  = '0;
        arb_sum  = '0;
        arb_cand = '0;
        for (int k = 0; k < int'(CH_COUNT); k++) begin
            arb_sum = {1'b0, rr_ptr_q} + (CHW+1)'(k);
            if (arb_sum >= (CHW+1)'(CH_COUNT)) begin
                arb_sum = arb_sum - (CHW+1)'(CH_COUNT);
            end
            arb_cand = arb_sum[CHW-1:0];
            if (!gnt && req[arb_cand]) begin
                gnt     = 1'b1;
                gnt_idx = arb_cand;
            end
        end
        if (fifo_full) begin
            gnt = 1'b0;
        end
        rr_ptr_d = rr_ptr_q;
        if (gnt) begin
            rr_ptr_d = (gnt_idx == CHW'(CH_COUNT - 1)) ? '0 : gnt_idx + CHW'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < int'(CH_COUNT); i++) begin
            state_d[i]     = state_q[i];
            hold_ts_d[i]   = hold_ts_q[i];
            hold_step_d[i] = hold_step_q[i];
            seen_d[i]      = seen_q[i];
            ovf_hit[i]     = 1'b0;
            unique case (state_q[i])
                StIdle: if (ch_enable[i]) state_d[i] = StArm;
                StArm:  state_d[i] = StWait;
                StWait: begin
                    if (ch_locked[i]) begin
                        state_d[i]     = StPend;
                        hold_ts_d[i]   = ch_ts[96*i +: 96];
                        hold_step_d[i] = 1'b0;
                        seen_d[i]      = 1'b0;
                    end else if (ch_step[i]) begin
                        if (StepEvtEn) begin
                            state_d[i]     = StPend;
                            hold_ts_d[i]   = '0;
                            hold_step_d[i] = 1'b1;
                            seen_d[i]      = 1'b0;
                        end else begin
                            state_d[i] = StArm;
                        end
                    end
                end
                StPend: begin
                    if (gnt && gnt_idx == CHW'(i)) state_d[i] = StArm;
                    // Held ts is never overwritten; only the first differing lock counts.
                    if (ch_locked[i] && ch_ts[96*i +: 96] != hold_ts_q[i] && !seen_q[i]) begin
                        ovf_hit[i] = 1'b1;
                        seen_d[i]  = 1'b1;
                    end
                end
            endcase
            if (!ch_enable[i]) state_d[i] = StIdle;
            arm_d[i] = (state_d[i] == StArm);
        end
    end

    always_comb begin
        ovf_inc = '0;
        for (int i = 0; i < int'(CH_COUNT); i++) begin
            ovf_inc = ovf_inc + OCW'(ovf_hit[i]);
        end
        ovf_sum = {1'b0, ovf_q} + 17'(ovf_inc);
        if (clr_ovf) begin
            ovf_d = '0;
        end else if (ovf_sum[16]) begin
            ovf_d = 16'hFFFF;
        end else begin
            ovf_d = ovf_sum[15:0];
        end
    end

    assign fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && m_evt_ready;
    assign count_d    = count_q + {{PW{1'b0}}, gnt} - {{PW{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (gnt) begin
            mem_q[wr_ptr_q] <= {hold_step_q[gnt_idx], gnt_idx, hold_ts_q[gnt_idx]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(CH_COUNT); i++) begin
                state_q[i]   <= StIdle;
                hold_ts_q[i] <= '0;
            end
            hold_step_q <= '0;
            seen_q      <= '0;
            ch_arm_q    <= '0;
            rr_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= '0;
        end else begin
            for (int i = 0; i < int'(CH_COUNT); i++) begin
                state_q[i]   <= state_d[i];
                hold_ts_q[i] <= hold_ts_d[i];
            end
            hold_step_q <= hold_step_d;
            seen_q      <= seen_d;
            ch_arm_q    <= arm_d;
            rr_ptr_q    <= rr_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            if (gnt) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Head is masked while empty so the stream reads zero out of reset.
    assign head        = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign m_evt_ts    = head[95:0];
    assign m_evt_ch    = head[96 +: CHW];
    assign m_evt_step  = StepEvtEn & head[EW-1];
    assign m_evt_valid = !fifo_empty;
    assign fifo_level  = count_q;
    assign ovf_count   = ovf_q;
    assign ch_arm      = ch_arm_q;

endmodule
